// File: rtl/quad_gpio_led_pkg.sv
// Shared constants and helpers for the quad GPIO LED conditioner:
// channel count, default blink patterns and prescaler sizing.
package quad_gpio_led_pkg;

  localparam int NCH = 8;

  // Channel n plays byte n, LSB first: ch0 steady, ch4 0,0,1,1,... etc.
  localparam logic [63:0] DEFAULT_PATTERN = 64'hFF_F0_AA_CC_80_A0_0F_FF;

  typedef logic [2:0] step_idx_t;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/quad_gpio_led_if.sv
// GPIO-level-in / LED-out bundle between the GPIO register block and the
// LED conditioner; slave is the conditioner side.
interface quad_gpio_led_if;

  logic [quad_gpio_led_pkg::NCH-1:0] i_gpio;
  logic [quad_gpio_led_pkg::NCH-1:0] o_led;
  logic                              o_tick;

  modport slave (
    input  i_gpio,
    output o_led,
    output o_tick
  );

  modport master (
    output i_gpio,
    input  o_led,
    input  o_tick
  );

endinterface

// File: rtl/quad_gpio_led_chan.sv
// One LED channel: enable edge detect, 3-bit pattern step index and the
// registered (optionally inverted) LED output.
module quad_gpio_led_chan
  import quad_gpio_led_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_tick,
  input  logic       i_pwm_on,
  input  logic [7:0] i_pattern,
  output logic       o_led
);

  logic      prev_en_q;
  step_idx_t idx_q, idx_d;
  logic      led_q, led_d;
  logic      rise;
  logic      lit;

  always_comb begin
    rise  = i_en & ~prev_en_q;
    lit   = i_en & i_pattern[idx_q] & i_pwm_on;
    led_d = lit ^ ACTIVE_LOW;
    idx_d = idx_q;
    // A fresh enable restarts at bit 0 even if a step tick lands on it.
    if (!i_en) begin
      idx_d = '0;
    end else if (rise) begin
      idx_d = '0;
    end else if (i_tick) begin
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_en_q <= 1'b0;
      idx_q     <= '0;
      led_q     <= ACTIVE_LOW;
    end else begin
      prev_en_q <= i_en;
      idx_q     <= idx_d;
      led_q     <= led_d;
    end
  end

  assign o_led = led_q;

endmodule

// File: rtl/quad_gpio_led.sv
// Quad GPIO LED conditioner top: shared step prescaler, 8 pattern channels.
// Define QUAD_GPIO_LED_PWM_EN to add a free-running PWM dimmer on all LEDs.
module quad_gpio_led
  import quad_gpio_led_pkg::*;
#(
  parameter int          CLK_FREQ_HZ = 27000000,
  parameter int          TICK_HZ     = 8,
  parameter logic [63:0] PATTERN     = DEFAULT_PATTERN,
  parameter int          ACTIVE_LOW  = 0,
  parameter int          PWM_BITS    = 4,
  parameter int          DUTY        = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  quad_gpio_led_if.slave   bus
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, TICK_HZ);
  localparam int CW  = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  // Refuse to elaborate a prescaler that cannot produce a one-cycle strobe.
  if (DIV < 2 || PWM_BITS < 1 || DUTY < 0) begin : g_cfg_error
    quad_gpio_led_invalid_parameter_configuration u_bad ();
  end

  logic [CW-1:0]  cnt_q, cnt_d;
  logic           tick_q, tick_d;
  logic           pwm_on;
  logic [NCH-1:0] led_w;

  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_q == LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

`ifdef QUAD_GPIO_LED_PWM_EN
  localparam bit PWM_FULL = (DUTY >= (1 << PWM_BITS));
  localparam logic [PWM_BITS:0] DUTY_V = PWM_FULL ? '0 : (PWM_BITS + 1)'(DUTY);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pwm_on = PWM_FULL | ({1'b0, pwm_cnt_q} < DUTY_V);
`else
  assign pwm_on = 1'b1;
`endif

  for (genvar n = 0; n < NCH; n++) begin : g_chan
    quad_gpio_led_chan #(
      .ACTIVE_LOW (ACTIVE_LOW != 0)
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (bus.i_gpio[n]),
      .i_tick    (tick_q),
      .i_pwm_on  (pwm_on),
      .i_pattern (PATTERN[8*n +: 8]),
      .o_led     (led_w[n])
    );
  end

  assign bus.o_led  = led_w;
  assign bus.o_tick = tick_q;

endmodule

// File: tb/tb_quad_gpio_led.sv
// Bench for quad_gpio_led: directed scenarios plus random enables/resets,
// checked every cycle against a step-count model of the blink rules.
module tb_quad_gpio_led;

  localparam int          CLK_HZ = 80;
  localparam int          TICK   = 8;
  localparam int          DIV    = CLK_HZ / TICK;
  localparam logic [63:0] PAT    = 64'hFF_F0_AA_CC_80_A0_0F_FF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quad_gpio_led_if ifa ();
  quad_gpio_led_if ifb ();

  // dut_a: active-high, dimmed to 4/16 when PWM is built in.
  quad_gpio_led #(
    .CLK_FREQ_HZ(CLK_HZ), .TICK_HZ(TICK), .PATTERN(PAT),
    .ACTIVE_LOW(0), .PWM_BITS(4), .DUTY(4)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(ifa.slave)
  );

  // dut_b: active-low, PWM duty saturated so it is never dimmed.
  quad_gpio_led #(
    .CLK_FREQ_HZ(CLK_HZ), .TICK_HZ(TICK), .PATTERN(PAT),
    .ACTIVE_LOW(1), .PWM_BITS(4), .DUTY(16)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(ifb.slave)
  );

  int          nvec = 0;
  int          nerr = 0;
  logic [63:0] pat_v;
  int          k;          // edges since reset released
  int          steps [8];  // ticks consumed since this channel's last (re)arm
  bit          prev [8];
  logic [7:0]  exp_a, exp_b;
  logic        exp_tick;

  task automatic model(input logic r, input logic [7:0] g);
    bit tick_in, pwm_a, lit;
    if (r) begin
      k = 0;
      for (int n = 0; n < 8; n++) begin
        steps[n] = 0;
        prev[n]  = 1'b0;
      end
      exp_a    = 8'h00;
      exp_b    = 8'hFF;
      exp_tick = 1'b0;
    end else begin
      tick_in = (k > 0) && (k % DIV == 0);
`ifdef QUAD_GPIO_LED_PWM_EN
      pwm_a = ((k % 16) < 4);
`else
      pwm_a = 1'b1;
`endif
      for (int n = 0; n < 8; n++) begin
        lit      = g[n] && pat_v[8*n + (steps[n] % 8)];
        exp_a[n] = lit & pwm_a;
        exp_b[n] = ~lit;
        if (!g[n] || !prev[n]) steps[n] = 0;
        else if (tick_in)      steps[n] = steps[n] + 1;
        prev[n] = g[n];
      end
      k = k + 1;
      exp_tick = (k % DIV == 0);
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, req);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] g);
    rst        = r;
    ifa.i_gpio = g;
    ifb.i_gpio = g;
    @(negedge clk);
    model(r, g);
    chk("led_a",  ifa.o_led, exp_a);
    chk("led_b",  ifb.o_led, exp_b);
    chk("tick_a", {7'b0, ifa.o_tick}, {7'b0, exp_tick});
    chk("tick_b", {7'b0, ifb.o_tick}, {7'b0, exp_tick});
  endtask

  // LED state of channel 4 seen through the never-dimmed active-low DUT.
  function automatic logic [7:0] lit4();
    return {7'b0, ~ifb.o_led[4]};
  endfunction

  initial begin
    logic [7:0] cc_seq;
    logic [7:0] g;
    bit         found;
    int         ones;

    pat_v  = PAT;
    cc_seq = 8'hCC;
    rst    = 1'b1;
    ifa.i_gpio = 8'hFF;
    ifb.i_gpio = 8'hFF;

    // Reset with all enables high: outputs parked.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hFF);
      chk("rst_led_a", ifa.o_led, 8'h00);
      chk("rst_led_b", ifb.o_led, 8'hFF);
      chk("rst_tick", {7'b0, ifa.o_tick}, 8'h00);
    end

    // Steady channel 0 and the tick period.
    for (int c = 1; c <= 40; c++) begin
      step(1'b0, 8'h01);
      if (c >= 2) chk("ch0_steady", {7'b0, ~ifb.o_led[0]}, 8'h01);
      if (c == 9 || c == 19) chk("tick_low", {7'b0, ifa.o_tick}, 8'h00);
      if (c == 10 || c == 20 || c == 30) chk("tick_high", {7'b0, ifa.o_tick}, 8'h01);
    end

    // Channel 4 (8'hCC) playback, one step per tick, wrapping after step 7.
    step(1'b1, 8'h10);
    for (int c = 1; c <= 100; c++) begin
      step(1'b0, 8'h10);
      if (c % 10 == 5) chk("cc_step", lit4(), {7'b0, cc_seq[(c / 10) % 8]});
    end

    // Disable at index 5, then re-arm on a tick cycle.
    step(1'b1, 8'h10);
    for (int c = 1; c <= 55; c++) step(1'b0, 8'h10);
    step(1'b0, 8'h00);
    chk("disable_off", lit4(), 8'h00);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ifa.o_tick) found = 1'b1;
      else step(1'b0, 8'h00);
    end
    chk("tick_found", {7'b0, found}, 8'h01);
    step(1'b0, 8'h10);
    for (int e = 1; e <= 25; e++) begin
      step(1'b0, 8'h10);
      if (e == 15) chk("rearm_idx1", lit4(), 8'h00);
      if (e == 25) chk("rearm_idx2", lit4(), 8'h01);
    end

    // Reset mid-pattern at index 3; held enable counts as a new rise.
    step(1'b1, 8'h10);
    for (int c = 1; c <= 35; c++) step(1'b0, 8'h10);
    step(1'b1, 8'h10);
    step(1'b1, 8'h10);
    for (int c = 1; c <= 25; c++) begin
      step(1'b0, 8'h10);
      if (c == 5)  chk("rst_restart_b0", lit4(), 8'h00);
      if (c == 25) chk("rst_restart_b2", lit4(), 8'h01);
    end

`ifdef QUAD_GPIO_LED_PWM_EN
    // Dimming: 4 of 16 cycles on, saturated duty always on.
    step(1'b1, 8'h01);
    for (int c = 1; c <= 16; c++) step(1'b0, 8'h01);
    ones = 0;
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 8'h01);
      if (ifa.o_led[0]) ones++;
      chk("pwm_full", {7'b0, ifb.o_led[0]}, 8'h00);
    end
    chk("pwm_duty", 8'(ones), 8'd4);
`else
    ones = 0;
`endif

    // Random enables with sparse toggles and occasional resets.
    g = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 8; n++)
        if ($urandom_range(15) == 0) g[n] = ~g[n];
      step(($urandom_range(499) == 0), g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
